// File: rtl/regwb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regwb_arbiter_pkg
// Shared definitions for the register-file writeback arbiter:
//   WORD_WIDTH     default data word width
//   REGADDR_WIDTH  default register address width
//   pri_e          round-robin priority state (PRI_ALU=0, PRI_MEM=1)
// ----------------------------------------------------------------------------
package regwb_arbiter_pkg;

    localparam int WORD_WIDTH    = 32;
    localparam int REGADDR_WIDTH = 5;

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_MEM = 1'b1
    } pri_e;

endpackage

// File: rtl/regwb_arbiter_if.sv
// ----------------------------------------------------------------------------
// regwb_arbiter_if
// Bundles the two writeback requesters, the decode-stage source registers,
// the hazard flag and the register-file write port.
//   master : requester / decode / register-file side
//   slave  : arbiter side (drives ready, hazard and the write port)
// ----------------------------------------------------------------------------
interface regwb_arbiter_if
    import regwb_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH    = regwb_arbiter_pkg::WORD_WIDTH,
    parameter int REGADDR_WIDTH = regwb_arbiter_pkg::REGADDR_WIDTH
);
    // requester 0: ALU writeback
    logic                     alu_valid;
    logic [REGADDR_WIDTH-1:0] alu_reg;
    logic [WORD_WIDTH-1:0]    alu_data;
    logic                     alu_ready;
    // requester 1: load writeback
    logic                     mem_valid;
    logic [REGADDR_WIDTH-1:0] mem_reg;
    logic [WORD_WIDTH-1:0]    mem_data;
    logic                     mem_ready;
    // decode-stage hazard query
    logic [REGADDR_WIDTH-1:0] rs_addr;
    logic [REGADDR_WIDTH-1:0] rt_addr;
    logic                     hazard;
    // register-file write port
    logic                     reg_wrt;
    logic [REGADDR_WIDTH-1:0] wrt_reg;
    logic [WORD_WIDTH-1:0]    wrt_dt;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        output rs_addr, rt_addr,
        input  alu_ready, mem_ready, hazard,
        input  reg_wrt, wrt_reg, wrt_dt
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        input  rs_addr, rt_addr,
        output alu_ready, mem_ready, hazard,
        output reg_wrt, wrt_reg, wrt_dt
    );

endinterface

// File: rtl/regwb_arbiter_reg_match.sv
// ----------------------------------------------------------------------------
// reg_match
// Register-address comparator used by the hazard logic.
//   i_a, i_b  register addresses to compare
//   o_match   1 when equal and nonzero (register 0 never creates a hazard)
// ----------------------------------------------------------------------------
module reg_match
    import regwb_arbiter_pkg::*;
#(
    parameter int REGADDR_WIDTH = regwb_arbiter_pkg::REGADDR_WIDTH
) (
    input  logic [REGADDR_WIDTH-1:0] i_a,
    input  logic [REGADDR_WIDTH-1:0] i_b,
    output logic                     o_match
);

    assign o_match = (i_a == i_b) && (i_a != '0);

endmodule

// File: rtl/regwb_arbiter.sv
// ----------------------------------------------------------------------------
// regwb_arbiter
// Two-requester round-robin arbiter for the register-file write port.
//   clk  single clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  regwb_arbiter_if.slave: ALU/MEM valid-ready requests, decode source
//        registers and hazard flag, registered register-file write port
// A grant is combinational from the valid inputs and the priority bit; the
// granted write reaches the register file one cycle later.
// ----------------------------------------------------------------------------
module regwb_arbiter
    import regwb_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH    = regwb_arbiter_pkg::WORD_WIDTH,
    parameter int REGADDR_WIDTH = regwb_arbiter_pkg::REGADDR_WIDTH
) (
    input logic            clk,
    input logic            rst,
    regwb_arbiter_if.slave bus
);

    pri_e                     r_pri;
    pri_e                     w_pri_nxt;
    logic                     w_alu_gnt;
    logic                     w_mem_gnt;
    logic                     r_reg_wrt;
    logic [REGADDR_WIDTH-1:0] r_wrt_reg;
    logic [WORD_WIDTH-1:0]    r_wrt_dt;
    logic [5:0]               w_match;

    // Priority state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pri <= PRI_ALU;
        end else begin
            r_pri <= w_pri_nxt;
        end
    end

    // Grant and next priority. Ready is held low while rst is asserted so no
    // request is consumed during reset and it stays pending for later.
    always_comb begin
        w_alu_gnt = 1'b0;
        w_mem_gnt = 1'b0;
        w_pri_nxt = r_pri;
        if (!rst) begin
            if (bus.alu_valid && (!bus.mem_valid || r_pri == PRI_ALU)) begin
                w_alu_gnt = 1'b1;
            end else if (bus.mem_valid) begin
                w_mem_gnt = 1'b1;
            end
        end
        if (w_alu_gnt) begin
            w_pri_nxt = PRI_MEM;
        end else if (w_mem_gnt) begin
            w_pri_nxt = PRI_ALU;
        end
    end

    // Output register: one-cycle write pulse. Writes to register 0 are
    // consumed but suppressed here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_wrt <= 1'b0;
            r_wrt_reg <= '0;
            r_wrt_dt  <= '0;
        end else if (w_alu_gnt) begin
            r_reg_wrt <= (bus.alu_reg != '0);
            r_wrt_reg <= bus.alu_reg;
            r_wrt_dt  <= bus.alu_data;
        end else if (w_mem_gnt) begin
            r_reg_wrt <= (bus.mem_reg != '0);
            r_wrt_reg <= bus.mem_reg;
            r_wrt_dt  <= bus.mem_data;
        end else begin
            r_reg_wrt <= 1'b0;
        end
    end

    // Hazard comparators: even index vs rs_addr, odd vs rt_addr;
    // pairs 0-1 ALU request, 2-3 MEM request, 4-5 in-flight write.
    for (genvar g = 0; g < 6; g++) begin : g_match
        reg_match #(
            .REGADDR_WIDTH(REGADDR_WIDTH)
        ) u_match (
            .i_a    ((g < 2) ? bus.alu_reg : ((g < 4) ? bus.mem_reg : r_wrt_reg)),
            .i_b    ((g % 2 == 1) ? bus.rt_addr : bus.rs_addr),
            .o_match(w_match[g])
        );
    end

    assign bus.hazard    = (bus.alu_valid && (|w_match[1:0]))
                         || (bus.mem_valid && (|w_match[3:2]))
                         || (r_reg_wrt     && (|w_match[5:4]));
    assign bus.alu_ready = w_alu_gnt;
    assign bus.mem_ready = w_mem_gnt;
    assign bus.reg_wrt   = r_reg_wrt;
    assign bus.wrt_reg   = r_wrt_reg;
    assign bus.wrt_dt    = r_wrt_dt;

endmodule

// File: tb/tb_regwb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regwb_arbiter
// Directed bench for regwb_arbiter. A small reference model tracks the
// round-robin priority and the last expected write; expected writes are
// queued when a request is driven and compared one cycle later.
// ----------------------------------------------------------------------------
module tb_regwb_arbiter;

    localparam int WW = 32;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regwb_arbiter_if #(.WORD_WIDTH(WW), .REGADDR_WIDTH(RW)) bus ();

    regwb_arbiter #(
        .WORD_WIDTH   (WW),
        .REGADDR_WIDTH(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic          v;
        logic [RW-1:0] r;
        logic [WW-1:0] d;
    } wr_t;

    wr_t           sb[$];
    int            checks = 0;
    int            errors = 0;
    logic          m_pri;      // 0: ALU wins ties, 1: MEM wins ties
    logic          m_out_v;    // expected reg_wrt currently on the port
    logic [RW-1:0] m_out_r;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic hit(input logic [RW-1:0] a, input logic [RW-1:0] rs,
                                 input logic [RW-1:0] rt);
        return (a != 0) && (a == rs || a == rt);
    endfunction

    // Drive one cycle of requests, check the combinational outputs against
    // the model and queue the expected write.
    task automatic drive(input string tag,
                         input logic av, input logic [RW-1:0] ar, input logic [WW-1:0] ad,
                         input logic mv, input logic [RW-1:0] mr, input logic [WW-1:0] md,
                         input logic [RW-1:0] rs, input logic [RW-1:0] rt);
        logic ga, gm, hz;
        bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
        bus.rs_addr   = rs; bus.rt_addr = rt;
        #1;
        ga = av && (!mv || m_pri == 1'b0);
        gm = mv && !ga;
        hz = (av && hit(ar, rs, rt)) || (mv && hit(mr, rs, rt))
           || (m_out_v && hit(m_out_r, rs, rt));
        chk({tag, ".alu_ready"}, bus.alu_ready, ga);
        chk({tag, ".mem_ready"}, bus.mem_ready, gm);
        chk({tag, ".hazard"}, bus.hazard, hz);
        if (ga) begin
            sb.push_back(wr_t'{v: (ar != 0), r: ar, d: ad});
            m_pri = 1'b1;
        end else if (gm) begin
            sb.push_back(wr_t'{v: (mr != 0), r: mr, d: md});
            m_pri = 1'b0;
        end else begin
            sb.push_back(wr_t'{v: 1'b0, r: '0, d: '0});
        end
    endtask

    // Advance one clock and compare the registered write port.
    task automatic edge_check(input string tag);
        wr_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".reg_wrt"}, bus.reg_wrt, e.v);
            if (e.v) begin
                chk({tag, ".wrt_reg"}, bus.wrt_reg, e.r);
                chk({tag, ".wrt_dt"}, bus.wrt_dt, e.d);
            end
            m_out_v = e.v;
            m_out_r = e.r;
        end
    endtask

    initial begin
        rst = 1'b1;
        m_pri = 1'b0;
        m_out_v = 1'b0;
        m_out_r = '0;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd1; bus.alu_data = 32'h11;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd2; bus.mem_data = 32'h22;
        bus.rs_addr = '0; bus.rt_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.reg_wrt", bus.reg_wrt, 1'b0);
        chk("reset.wrt_reg", bus.wrt_reg, 5'd0);
        chk("reset.wrt_dt", bus.wrt_dt, 32'd0);
        chk("reset.alu_ready", bus.alu_ready, 1'b0);
        chk("reset.mem_ready", bus.mem_ready, 1'b0);
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        rst = 1'b0;

        // single ALU write, granted on first edge after release
        drive("alu5", 1, 5'd5, 32'h0000_00AA, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        edge_check("alu5");

        // MEM write to register 0: consumed, no write
        drive("mem0", 0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        edge_check("mem0");

        // sustained contention: ALU, MEM, ALU, MEM with no bubble
        drive("rr0", 1, 5'd3, 32'd1, 1, 5'd4, 32'd2, 5'd0, 5'd0);
        edge_check("rr0");
        drive("rr1", 1, 5'd3, 32'd3, 1, 5'd4, 32'd2, 5'd0, 5'd0);
        edge_check("rr1");
        drive("rr2", 1, 5'd3, 32'd3, 1, 5'd4, 32'd4, 5'd0, 5'd0);
        edge_check("rr2");
        drive("rr3", 1, 5'd3, 32'd5, 1, 5'd4, 32'd4, 5'd0, 5'd0);
        edge_check("rr3");

        // same register from both: ALU first, MEM last
        drive("same0", 1, 5'd12, 32'h1, 1, 5'd12, 32'h2, 5'd0, 5'd0);
        edge_check("same0");
        drive("same1", 0, 5'd12, 32'h1, 1, 5'd12, 32'h2, 5'd0, 5'd0);
        edge_check("same1");

        // idle: no write next cycle
        drive("idle", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        edge_check("idle");

        // hazard from pending ALU request, then from the in-flight write
        drive("hz_alu", 1, 5'd7, 32'h77, 0, 5'd0, 32'h0, 5'd7, 5'd0);
        edge_check("hz_alu");
        drive("hz_wrt", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd7);
        edge_check("hz_wrt");
        drive("hz_zero", 1, 5'd0, 32'h5, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        edge_check("hz_zero");
        drive("hz_mem", 0, 5'd0, 32'h0, 1, 5'd6, 32'h66, 5'd8, 5'd6);
        edge_check("hz_mem");

        // reset in the cycle after a grant to register 9
        drive("r9", 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd10; bus.alu_data = 32'hA0;
        bus.mem_valid = 1'b1; bus.mem_reg = 5'd11; bus.mem_data = 32'hB0;
        #1;
        chk("rst_mid.reg_wrt", bus.reg_wrt, 1'b0);
        chk("rst_mid.wrt_reg", bus.wrt_reg, 5'd0);
        chk("rst_mid.wrt_dt", bus.wrt_dt, 32'd0);
        chk("rst_mid.alu_ready", bus.alu_ready, 1'b0);
        chk("rst_mid.mem_ready", bus.mem_ready, 1'b0);
        void'(sb.pop_front());
        m_pri = 1'b0;
        m_out_v = 1'b0;
        m_out_r = '0;
        @(posedge clk);
        #1;
        chk("rst_hold.reg_wrt", bus.reg_wrt, 1'b0);
        rst = 1'b0;
        drive("post0", 1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 5'd0, 5'd0);
        edge_check("post0");
        drive("post1", 0, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 5'd0, 5'd0);
        edge_check("post1");
        drive("post2", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        edge_check("post2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/regwb_arbiter.md
REGWB_ARBITER -- requirements
Module: regwb_arbiter

Interface
REQ-001 Parameters SHALL be WORD_WIDTH, default 32, data word width; REGADDR_WIDTH, default 5, register address width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 alu_valid  input  1  requester 0 (ALU writeback) has a pending write.
REQ-005 alu_reg  input  REGADDR_WIDTH  requester 0 destination register.
REQ-006 alu_data  input  WORD_WIDTH  requester 0 write data.
REQ-007 alu_ready  output  1  requester 0 write accepted this cycle.
REQ-008 mem_valid, mem_reg, mem_data, mem_ready  same widths and directions as REQ-004..007, for requester 1 (load writeback).
REQ-009 rs_addr, rt_addr  input  REGADDR_WIDTH  source registers of the instruction in decode.
REQ-010 hazard  output  1  a pending or in-flight write targets rs_addr or rt_addr.
REQ-011 reg_wrt  output  1  register-file write enable.
REQ-012 wrt_reg  output  REGADDR_WIDTH  register-file write address.
REQ-013 wrt_dt  output  WORD_WIDTH  register-file write data.

Function
REQ-014 A request is transferred in the cycle where valid and ready are both 1; a requester SHALL hold valid, reg, data stable until transferred.
REQ-015 At most one ready SHALL be 1 per cycle; ready is combinational from valid inputs and current priority state.
REQ-016 Arbitration SHALL be round-robin over two states: PRI_ALU (ALU wins ties) and PRI_MEM (MEM wins ties).
REQ-017 With one valid requester, that requester SHALL be granted regardless of priority state.
REQ-018 After a grant to ALU the state SHALL become PRI_MEM; after a grant to MEM, PRI_ALU; with no grant the state SHALL hold.
REQ-019 The granted request SHALL appear on reg_wrt/wrt_reg/wrt_dt exactly one cycle after the transfer cycle (registered outputs, latency 1), for one cycle only.
REQ-020 A granted request with destination register 0 SHALL be consumed (ready=1) but SHALL produce reg_wrt=0 in the following cycle; wrt_reg/wrt_dt values are then don't-care.
REQ-021 Back-to-back grants SHALL be supported: sustained throughput one write per cycle with no bubble.
REQ-022 Simultaneous valid requests to the same nonzero register SHALL be serialized by priority; the later-granted one SHALL be written last.
REQ-023 hazard SHALL be 1 when any of: alu_valid with alu_reg equal rs_addr or rt_addr; mem_valid likewise; reg_wrt=1 with wrt_reg equal rs_addr or rt_addr; comparisons against register 0 SHALL never raise hazard.
REQ-024 hazard SHALL be combinational with no dependency on the current grant.
REQ-025 When neither requester is valid, reg_wrt SHALL be 0 in the next cycle.

Reset
REQ-026 While rst=1: reg_wrt=0, wrt_reg=0, wrt_dt=0, priority state=PRI_ALU, alu_ready=0, mem_ready=0.
REQ-027 Assertion of rst mid-operation SHALL abandon any registered in-flight write (reg_wrt forced 0 immediately); requests held by requesters remain pending and are arbitrated after release.
REQ-028 The first grant after reset release SHALL be on the first rising edge with rst=0.

Structure
REQ-029 WORD_WIDTH, REGADDR_WIDTH and the priority-state encoding (PRI_ALU=0, PRI_MEM=1) SHALL live in the shared defines file.
REQ-030 Register-address match logic for hazard SHALL be one sub-module, reg_match, instantiated per compared pair.
REQ-031 No storage beyond the output register, the priority bit and ready logic SHALL be added; regwb_arbiter drives the register-file write port directly.

Verification
REQ-032 Reset then alu_valid=1, alu_reg=5, alu_data=32'h0000_00AA, mem_valid=0 -> alu_ready=1 same cycle; next cycle reg_wrt=1, wrt_reg=5, wrt_dt=32'h0000_00AA.
REQ-033 Both valid continuously, alu_reg=3/alu_data=1, mem_reg=4/mem_data=2, data changed after each grant -> grants alternate ALU, MEM, ALU, MEM starting with ALU; one write per cycle.
REQ-034 mem_valid=1, mem_reg=0, mem_data=32'hFFFF_FFFF -> mem_ready=1; next cycle reg_wrt=0.
REQ-035 alu_valid=1, alu_reg=7, rs_addr=7, rt_addr=0 -> hazard=1; rs_addr=0, rt_addr=0, alu_reg=0 -> hazard=0.
REQ-036 rst asserted in cycle following a grant to reg 9 -> reg_wrt=0 asynchronously, no write to reg 9; after release pending ALU request granted first.
REQ-037 Both valid targeting reg 12 with data 32'h1 (ALU) and 32'h2 (MEM), state PRI_ALU -> writes 32'h1 then 32'h2 on consecutive cycles.
